// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RV32I pipeline (F/D/E/M/W).
// Produces combinational stall/flush controls and EX operand-forwarding selects.
// Runs a two-state wait FSM for multi-cycle data-memory accesses, with a timeout
// abort and a sticky error flag, and keeps a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             LoadE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemBusy,
  output logic             TimeoutErr,
  output logic [CNT_W-1:0] StallCount
);

  // Wait counter only has to reach TIMEOUT-1.
  localparam int              WC_W    = $clog2(TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Forwarding select encodings.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  logic [0:0]       state_q, state_d;
  logic [WC_W-1:0]  waitcnt_q, waitcnt_d;
  logic             terr_q, terr_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic             in_wait;
  logic             timeout_hit;
  logic             mem_pend;
  logic             mem_stall;
  logic             lw_hit;
  logic             lw_stall;
  logic             br_flush;
  logic             br_override;
  logic             cnt_en;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  // Forward from M when it writes the register, else from W, else regfile.
  // x0 is never forwarded since it always reads as zero.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       wr_m,
    input logic [4:0] rd_w,
    input logic       wr_w
  );
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return FWD_M;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return FWD_W;
    end else begin
      return FWD_RF;
    end
  endfunction

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Hazard detection: memory wait, load-use and branch override decisions.
  always_comb begin
    in_wait     = (state_q == ST_WAIT);
    timeout_hit = in_wait && (waitcnt_q == WC_LAST);
    mem_pend    = MemReqM && !MemReadyM;
    // On the timeout cycle the stall is released so the pipeline can move on.
    mem_stall   = mem_pend && !timeout_hit;
    lw_hit      = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    // A memory stall freezes everything; load-use and branch are re-evaluated later.
    lw_stall    = lw_hit && !mem_stall;
    br_flush    = PCSrcE && !mem_stall;
    // A taken branch squashes the dependent instruction, so no load-use stall.
    br_override = br_flush && lw_stall;
    cnt_en      = mem_stall || (lw_stall && !br_override);
    fwd_a       = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    fwd_b       = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  // Output drive; everything is held low while reset is asserted.
  always_comb begin
    StallF     = reset && (mem_stall || (lw_stall && !br_override));
    StallD     = reset && (mem_stall || (lw_stall && !br_override));
    StallE     = reset && mem_stall;
    StallM     = reset && mem_stall;
    FlushD     = reset && br_flush;
    FlushE     = reset && (br_flush || lw_stall);
    // W gets a bubble while data is pending, including the aborting timeout cycle.
    FlushW     = reset && mem_pend;
    ForwardAE  = reset ? fwd_a : FWD_RF;
    ForwardBE  = reset ? fwd_b : FWD_RF;
    MemBusy    = reset && in_wait;
    TimeoutErr = reset && terr_q;
    StallCount = reset ? scnt_q : '0;
  end

  // Memory wait FSM next-state, wait counter and sticky timeout flag.
  always_comb begin
    state_d   = state_q;
    waitcnt_d = waitcnt_q;
    terr_d    = terr_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_pend) begin
          state_d   = ST_WAIT;
          waitcnt_d = WC_ONE;
        end
      end
      ST_WAIT: begin
        // A dropped request ends the wait just like an acknowledge.
        if (MemReadyM || !MemReqM) begin
          state_d   = ST_IDLE;
          waitcnt_d = '0;
        end else if (timeout_hit) begin
          state_d   = ST_IDLE;
          waitcnt_d = '0;
          terr_d    = 1'b1;
        end else begin
          waitcnt_d = waitcnt_q + WC_ONE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        waitcnt_d = '0;
      end
    endcase
  end

  // Stall-cycle counter next value.
  always_comb begin
    scnt_d = scnt_q;
    if (cnt_en) begin
      scnt_d = sat_inc(scnt_q);
    end
  end

  // State registers; asynchronous reset drops any in-flight wait immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      waitcnt_q <= '0;
      terr_q    <= 1'b0;
      scnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      waitcnt_q <= waitcnt_d;
      terr_q    <= terr_d;
      scnt_q    <= scnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (TIMEOUT=4, CNT_W=4).
// Inputs are driven on the falling edge; expected control words are queued at
// drive time and compared 1 ns later against the combinational outputs.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  // Stall/flush group {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
  localparam logic [6:0] S_NONE  = 7'b0000000;
  localparam logic [6:0] S_MEM   = 7'b1111001;
  localparam logic [6:0] S_LW    = 7'b1100010;
  localparam logic [6:0] S_BR    = 7'b0000110;
  localparam logic [6:0] S_ABORT = 7'b0000001;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MemBusy, TimeoutErr;
  logic [CNT_W-1:0] StallCount;

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       loade, rwm, rww, pcsrc, req, rdy;
  } stim_t;

  typedef struct {
    string            name;
    int               idx;
    logic [12:0]      ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemBusy(MemBusy), .TimeoutErr(TimeoutErr), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] got_ctl();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
            ForwardAE, ForwardBE, MemBusy, TimeoutErr};
  endfunction

  task automatic drive(input stim_t s);
    Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
    RdE = s.rde; RdM = s.rdm; RdW = s.rdw;
    LoadE = s.loade; RegWriteM = s.rwm; RegWriteW = s.rww;
    PCSrcE = s.pcsrc; MemReqM = s.req; MemReadyM = s.rdy;
  endtask

  task automatic push(input string nm, input int idx, input logic [6:0] grp,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic mb, input logic te, input int cnt);
    exp_t e;
    e.name = nm;
    e.idx  = idx;
    e.ctl  = {grp, fa, fb, mb, te};
    e.cnt  = CNT_W'(cnt);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive('0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s = '0;
      case (i)
        0: begin
          s.loade = 1; s.rde = 5; s.rs1d = 5; s.pcsrc = 1; s.req = 1;
          s.rwm = 1; s.rdm = 3; s.rs1e = 3;
          push("reset", i, S_NONE, 2'b00, 2'b00, 0, 0, 0);
        end
        1: begin
          s.rww = 1; s.rdw = 6; s.rs2e = 6; s.req = 1;
          push("reset", i, S_NONE, 2'b00, 2'b00, 0, 0, 0);
        end
        default: begin
          reset = 1'b1;
          push("reset", i, S_NONE, 2'b00, 2'b00, 0, 0, 0);
        end
      endcase
      drive(s);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (got_ctl() !== e.ctl) begin
        n_err++;
        $display("FAIL %s[%0d] ctl got=%b exp=%b", e.name, e.idx, got_ctl(), e.ctl);
      end
      n_checks++;
      if (StallCount !== e.cnt) begin
        n_err++;
        $display("FAIL %s[%0d] StallCount got=%0d exp=%0d", e.name, e.idx, StallCount, e.cnt);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t s;
    exp_t  e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s = '0;
      case (i)
        0: begin s.loade = 1; s.rde = 5; s.rs1d = 5;
                 push("load_use", i, S_LW, 2'b00, 2'b00, 0, 0, 0); end
        1: push("load_use", i, S_NONE, 2'b00, 2'b00, 0, 0, 1);
        2: begin s.loade = 1; s.rde = 7; s.rs1d = 1; s.rs2d = 7;
                 push("load_use", i, S_LW, 2'b00, 2'b00, 0, 0, 1); end
        3: begin s.loade = 1; s.rde = 0; s.rs1d = 0; s.rs2d = 0;
                 push("load_use", i, S_NONE, 2'b00, 2'b00, 0, 0, 2); end
        4: begin s.loade = 1; s.rde = 5; s.rs1d = 6; s.rs2d = 4;
                 push("load_use", i, S_NONE, 2'b00, 2'b00, 0, 0, 2); end
        default: push("load_use", i, S_NONE, 2'b00, 2'b00, 0, 0, 2);
      endcase
      drive(s);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (got_ctl() !== e.ctl) begin
        n_err++;
        $display("FAIL %s[%0d] ctl got=%b exp=%b", e.name, e.idx, got_ctl(), e.ctl);
      end
      n_checks++;
      if (StallCount !== e.cnt) begin
        n_err++;
        $display("FAIL %s[%0d] StallCount got=%0d exp=%0d", e.name, e.idx, StallCount, e.cnt);
      end
    end
  endtask

  task automatic test_forward();
    stim_t s;
    exp_t  e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s = '0;
      case (i)
        0: begin s.rwm = 1; s.rdm = 3; s.rww = 1; s.rdw = 3; s.rs1e = 3;
                 push("forward", i, S_NONE, 2'b10, 2'b00, 0, 0, 0); end
        1: begin s.rwm = 1; s.rdm = 0; s.rww = 1; s.rdw = 3; s.rs1e = 3;
                 push("forward", i, S_NONE, 2'b01, 2'b00, 0, 0, 0); end
        2: begin s.rwm = 1; s.rdm = 4; s.rww = 1; s.rdw = 4; s.rs2e = 4;
                 push("forward", i, S_NONE, 2'b00, 2'b10, 0, 0, 0); end
        3: begin s.rdm = 4; s.rww = 1; s.rdw = 4; s.rs1e = 4; s.rs2e = 4;
                 push("forward", i, S_NONE, 2'b01, 2'b01, 0, 0, 0); end
        4: begin s.rdm = 4; s.rdw = 4; s.rs1e = 4; s.rs2e = 4;
                 push("forward", i, S_NONE, 2'b00, 2'b00, 0, 0, 0); end
        5: begin s.rwm = 1; s.rdm = 9; s.rs1e = 9; s.rww = 1; s.rdw = 6; s.rs2e = 6;
                 s.req = 1;
                 push("forward", i, S_MEM, 2'b10, 2'b01, 0, 0, 0); end
        6: push("forward", i, S_NONE, 2'b00, 2'b00, 1, 0, 1);
        default: push("forward", i, S_NONE, 2'b00, 2'b00, 0, 0, 1);
      endcase
      drive(s);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (got_ctl() !== e.ctl) begin
        n_err++;
        $display("FAIL %s[%0d] ctl got=%b exp=%b", e.name, e.idx, got_ctl(), e.ctl);
      end
      n_checks++;
      if (StallCount !== e.cnt) begin
        n_err++;
        $display("FAIL %s[%0d] StallCount got=%0d exp=%0d", e.name, e.idx, StallCount, e.cnt);
      end
    end
  endtask

  task automatic test_mem_wait();
    stim_t s;
    exp_t  e;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      s = '0;
      case (i)
        0: begin s.req = 1; push("mem_wait", i, S_MEM, 2'b00, 2'b00, 0, 0, 0); end
        1: begin s.req = 1; push("mem_wait", i, S_MEM, 2'b00, 2'b00, 1, 0, 1); end
        2: begin s.req = 1; push("mem_wait", i, S_MEM, 2'b00, 2'b00, 1, 0, 2); end
        3: begin s.req = 1; s.rdy = 1;
                 push("mem_wait", i, S_NONE, 2'b00, 2'b00, 1, 0, 3); end
        4: push("mem_wait", i, S_NONE, 2'b00, 2'b00, 0, 0, 3);
        5: begin s.req = 1; push("mem_wait", i, S_MEM, 2'b00, 2'b00, 0, 0, 3); end
        6: push("mem_wait", i, S_NONE, 2'b00, 2'b00, 1, 0, 4);
        7: push("mem_wait", i, S_NONE, 2'b00, 2'b00, 0, 0, 4);
        default: begin s.req = 1; s.rdy = 1;
                 push("mem_wait", i, S_NONE, 2'b00, 2'b00, 0, 0, 4); end
      endcase
      drive(s);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (got_ctl() !== e.ctl) begin
        n_err++;
        $display("FAIL %s[%0d] ctl got=%b exp=%b", e.name, e.idx, got_ctl(), e.ctl);
      end
      n_checks++;
      if (StallCount !== e.cnt) begin
        n_err++;
        $display("FAIL %s[%0d] StallCount got=%0d exp=%0d", e.name, e.idx, StallCount, e.cnt);
      end
    end
  endtask

  task automatic test_timeout();
    stim_t s;
    exp_t  e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s = '0;
      case (i)
        0: begin s.req = 1; push("timeout", i, S_MEM, 2'b00, 2'b00, 0, 0, 0); end
        1: begin s.req = 1; push("timeout", i, S_MEM, 2'b00, 2'b00, 1, 0, 1); end
        2: begin s.req = 1; push("timeout", i, S_MEM, 2'b00, 2'b00, 1, 0, 2); end
        3: begin s.req = 1; push("timeout", i, S_ABORT, 2'b00, 2'b00, 1, 0, 3); end
        4: begin s.req = 1; push("timeout", i, S_MEM, 2'b00, 2'b00, 0, 1, 3); end
        5: push("timeout", i, S_NONE, 2'b00, 2'b00, 1, 1, 4);
        default: push("timeout", i, S_NONE, 2'b00, 2'b00, 0, 1, 4);
      endcase
      drive(s);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (got_ctl() !== e.ctl) begin
        n_err++;
        $display("FAIL %s[%0d] ctl got=%b exp=%b", e.name, e.idx, got_ctl(), e.ctl);
      end
      n_checks++;
      if (StallCount !== e.cnt) begin
        n_err++;
        $display("FAIL %s[%0d] StallCount got=%0d exp=%0d", e.name, e.idx, StallCount, e.cnt);
      end
    end
  endtask

  task automatic test_priority();
    stim_t s;
    exp_t  e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s = '0;
      case (i)
        0: begin s.req = 1; s.pcsrc = 1; s.loade = 1; s.rde = 5; s.rs1d = 5;
                 push("priority", i, S_MEM, 2'b00, 2'b00, 0, 0, 0); end
        1: begin s.req = 1; s.pcsrc = 1; s.loade = 1; s.rde = 5; s.rs1d = 5;
                 push("priority", i, S_MEM, 2'b00, 2'b00, 1, 0, 1); end
        2: begin s.req = 1; s.rdy = 1; s.pcsrc = 1; s.loade = 1; s.rde = 5; s.rs1d = 5;
                 push("priority", i, S_BR, 2'b00, 2'b00, 1, 0, 2); end
        3: begin s.pcsrc = 1;
                 push("priority", i, S_BR, 2'b00, 2'b00, 0, 0, 2); end
        4: begin s.loade = 1; s.rde = 12; s.rs2d = 12;
                 push("priority", i, S_LW, 2'b00, 2'b00, 0, 0, 2); end
        default: push("priority", i, S_NONE, 2'b00, 2'b00, 0, 0, 3);
      endcase
      drive(s);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (got_ctl() !== e.ctl) begin
        n_err++;
        $display("FAIL %s[%0d] ctl got=%b exp=%b", e.name, e.idx, got_ctl(), e.ctl);
      end
      n_checks++;
      if (StallCount !== e.cnt) begin
        n_err++;
        $display("FAIL %s[%0d] StallCount got=%0d exp=%0d", e.name, e.idx, StallCount, e.cnt);
      end
    end
  endtask

  task automatic test_saturate();
    stim_t s;
    exp_t  e;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      s = '0;
      if (i < 18) begin
        s.loade = 1; s.rde = 8; s.rs1d = 8;
        push("saturate", i, S_LW, 2'b00, 2'b00, 0, 0, (i < 15) ? i : 15);
      end else begin
        push("saturate", i, S_NONE, 2'b00, 2'b00, 0, 0, 15);
      end
      drive(s);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (got_ctl() !== e.ctl) begin
        n_err++;
        $display("FAIL %s[%0d] ctl got=%b exp=%b", e.name, e.idx, got_ctl(), e.ctl);
      end
      n_checks++;
      if (StallCount !== e.cnt) begin
        n_err++;
        $display("FAIL %s[%0d] StallCount got=%0d exp=%0d", e.name, e.idx, StallCount, e.cnt);
      end
    end
  endtask

  // Runs right after test_timeout so TimeoutErr and StallCount start non-zero.
  task automatic test_async_reset();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        // Mid-cycle assertion while the FSM sits in WAIT.
        #1;
        reset = 1'b0;
        push("async_reset", i, S_NONE, 2'b00, 2'b00, 0, 0, 0);
      end else begin
        @(negedge clk);
        s = '0;
        s.req = (i < 5);
        s.rwm = 1; s.rdm = 3; s.rs1e = 3;
        case (i)
          0: push("async_reset", i, S_MEM, 2'b10, 2'b00, 0, 1, 4);
          1: push("async_reset", i, S_MEM, 2'b10, 2'b00, 1, 1, 5);
          2: push("async_reset", i, S_MEM, 2'b10, 2'b00, 1, 1, 6);
          4: begin reset = 1'b1;
                   push("async_reset", i, S_MEM, 2'b10, 2'b00, 0, 0, 0); end
          default: push("async_reset", i, S_NONE, 2'b10, 2'b00, 1, 0, 1);
        endcase
        drive(s);
      end
      #1;
      e = sb.pop_front();
      n_checks++;
      if (got_ctl() !== e.ctl) begin
        n_err++;
        $display("FAIL %s[%0d] ctl got=%b exp=%b", e.name, e.idx, got_ctl(), e.ctl);
      end
      n_checks++;
      if (StallCount !== e.cnt) begin
        n_err++;
        $display("FAIL %s[%0d] StallCount got=%0d exp=%0d", e.name, e.idx, StallCount, e.cnt);
      end
    end
  endtask

  initial begin
    drive('0);
    test_reset();
    test_load_use();
    test_forward();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    test_priority();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim_time got=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
